sm_ifetch_buffer: RTL and testbench
===================================

// Module: sm_ifetch_buffer
// PURPOSE
//  Instruction prefetch stage between sm_cpu's fetch port (imAddr/imData) and a variable-latency
//  instruction memory with a req/ack handshake. Prefetches sequential words into a small FIFO,
//  serves the CPU from its head and flushes on any non-sequential PC (branch, reset vector).
//  imValid=0 tells the CPU to hold its PC. All addresses are 32-bit word addresses (PC+1 = next).
// PARAMETERS
//  DEPTH       4   FIFO entries; power of two, >= 2
//  RESET_ADDR  0   expected first fetch address after reset
// PORTS
//  clk       in   1   clock; all state on posedge
//  rst_n     in   1   asynchronous active-low reset
//  imAddr    in   32  CPU fetch address (PC)
//  imData    out  32  instruction at FIFO head; valid only when imValid=1
//  imValid   out  1   imData matches imAddr; CPU consumes it this cycle
//  memReq    out  1   memory request, registered
//  memAddr   out  32  request address, registered, stable while memReq=1
//  memAck    in   1   one-cycle pulse: memData valid, request completed
//  memData   in   32  instruction word returned with memAck
// BEHAVIOUR
//  - State: FIFO (count 0..DEPTH), headAddr (address of head / next expected), fetchAddr
//    (next address to request), FSM {IDLE, REQ, DROP}. Only one request outstanding.
//  - Reset: memReq=0, memAddr=0, count=0, headAddr=fetchAddr=RESET_ADDR, FSM=IDLE; imValid=0.
//  - imValid = (count!=0) && (imAddr==headAddr), combinational; imData = head entry.
//    Pop when imValid=1: headAddr<=headAddr+1, count-1.
//  - Redirect when imAddr!=headAddr: flush FIFO (count<=0), headAddr<=imAddr,
//    fetchAddr<=imAddr. Redirect has priority over pop and over push of this cycle's ack data.
//  - IDLE: if no redirect and space (count_next < DEPTH) -> REQ, memReq<=1, memAddr<=fetchAddr.
//  - REQ: memReq/memAddr held until memAck. On memAck without redirect: push memData,
//    fetchAddr+1; if count_next < DEPTH stay REQ with memAddr<=fetchAddr+1 (back-to-back, 1 word
//    per cycle with zero-wait memory), else -> IDLE, memReq<=0. Redirect while REQ without ack
//    -> DROP (request keeps being held). Redirect in same cycle as ack -> data discarded, IDLE.
//  - DROP: memReq held; on memAck discard data -> IDLE. Redirects in DROP only update pointers.
//  - count_next accounts for same-cycle pop and push; push+pop on full FIFO is legal.
//  - Miss latency with zero-wait memory: redirect seen cycle N, memReq=1 in N+2, imValid=1 N+3.
//  - Pointers wrap modulo DEPTH; address arithmetic wraps modulo 2^32 (0xFFFFFFFF -> 0).
//  - Reset mid-request drops memReq immediately; memory must tolerate abandoned requests.
//  - memAck while FSM=IDLE is ignored.
// CONFIGURATION
//  SM_IFETCH_STATS_EN defined: adds output port missCount [31:0], reset 0, +1 on every cycle a
//  redirect with count!=0 or FSM!=IDLE occurs (the real flushes); wraps at 2^32.
//  Undefined: port and counter absent; all other behaviour identical.
// TESTING
//  1. Reset, imAddr=0, memory acks in the same cycle memReq=1 -> memAddr 0,1,2,3 on consecutive
//     cycles; imValid=1 from cycle 3 onward; imData=mem[0],mem[1],... one per cycle.
//  2. CPU stalls (imAddr held at 1), memory zero-wait -> FIFO fills to DEPTH=4, memReq drops;
//     imAddr steps -> refill resumes with no lost or duplicated words.
//  3. Branch: imAddr jumps 2->0x40 while FIFO holds 3..5 -> imValid=0, memAddr=0x40 two cycles
//     later, imData=mem[0x40] first valid word; stale 3..5 never presented.
//  4. Redirect while request to 6 waits 5 cycles for memAck -> memAddr stays 6 until ack, that data
//     discarded, next memAddr = new target.
//  5. Redirect in the ack cycle, and reset asserted mid-REQ -> data dropped; after reset
//     memReq=0, imValid=0, fetch restarts at RESET_ADDR.
//  6. With SM_IFETCH_STATS_EN: 3 branches during steady fetch -> missCount=3; none on reset start.

Source files
------------

// File: rtl/sm_ifetch_buffer.sv
// sm_ifetch_buffer: sequential instruction prefetch FIFO between the CPU fetch port
// and a variable-latency req/ack instruction memory. One request is outstanding at most.
// A fetch address that differs from the FIFO head flushes the FIFO and restarts fetching there.
// A response to a request issued before a redirect is waited out and discarded (DROP).
// Optional feature macro: SM_IFETCH_STATS_EN adds the missCount output (real flush counter).
module sm_ifetch_buffer #(
    parameter int          DEPTH      = 4,
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] imAddr,
    output logic [31:0] imData,
    output logic        imValid,
    output logic        memReq,
    output logic [31:0] memAddr,
    input  logic        memAck,
    input  logic [31:0] memData
`ifdef SM_IFETCH_STATS_EN
    ,
    output logic [31:0] missCount
`endif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    logic [31:0]      fifoMem [DEPTH];
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] wrPtr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] countNext;
    logic [31:0]      headAddr;
    logic [31:0]      fetchAddr;
    logic [1:0]       state;
    logic             redirect;
    logic             push;
    logic             pop;
    logic             hasSpace;

    // Head match, consume/fill decisions and the post-update occupancy
    always_comb begin
        redirect  = (imAddr != headAddr);
        pop       = (count != '0) && !redirect;
        // Ack data only lands for a live request that was not overtaken by a redirect
        push      = memAck && (state == ST_REQ) && !redirect;
        countNext = count;
        if (redirect) begin
            countNext = '0;
        end else begin
            countNext = count + CNT_W'(push) - CNT_W'(pop);
        end
        hasSpace  = (countNext < DEPTH_C);
    end

    assign imValid = pop;
    assign imData  = fifoMem[rdPtr];

    // FIFO storage write; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (push) begin
            fifoMem[wrPtr] <= memData;
        end
    end

    // Pointers, occupancy, address tracking and the request FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdPtr     <= '0;
            wrPtr     <= '0;
            count     <= '0;
            headAddr  <= RESET_ADDR;
            fetchAddr <= RESET_ADDR;
            state     <= ST_IDLE;
            memReq    <= 1'b0;
            memAddr   <= 32'd0;
        end else begin
            count <= countNext;
            if (redirect) begin
                rdPtr     <= '0;
                wrPtr     <= '0;
                headAddr  <= imAddr;
                fetchAddr <= imAddr;
            end else begin
                if (pop) begin
                    rdPtr    <= rdPtr + PTR_W'(1);
                    headAddr <= headAddr + 32'd1;
                end
                if (push) begin
                    wrPtr     <= wrPtr + PTR_W'(1);
                    fetchAddr <= fetchAddr + 32'd1;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (!redirect && hasSpace) begin
                        state   <= ST_REQ;
                        memReq  <= 1'b1;
                        memAddr <= fetchAddr;
                    end
                end
                ST_REQ: begin
                    if (memAck) begin
                        if (redirect) begin
                            state  <= ST_IDLE;
                            memReq <= 1'b0;
                        end else if (hasSpace) begin
                            // Back-to-back: memAddr equals fetchAddr while requesting
                            memAddr <= fetchAddr + 32'd1;
                        end else begin
                            state  <= ST_IDLE;
                            memReq <= 1'b0;
                        end
                    end else if (redirect) begin
                        // The in-flight request must still complete; its data is stale
                        state <= ST_DROP;
                    end
                end
                ST_DROP: begin
                    if (memAck) begin
                        state  <= ST_IDLE;
                        memReq <= 1'b0;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    memReq <= 1'b0;
                end
            endcase
        end
    end

`ifdef SM_IFETCH_STATS_EN
    // Count flushes that actually discard work: buffered words or an in-flight request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            missCount <= 32'd0;
        end else if (redirect && ((count != '0) || (state != ST_IDLE))) begin
            missCount <= missCount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sm_ifetch_buffer.sv
// Bench for sm_ifetch_buffer: queue-based reference model of the prefetch buffer, a
// randomized-latency memory responder and a CPU that advances on consumption and branches.
`timescale 1ns/1ps
module tb_sm_ifetch_buffer;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] imAddr = 32'd0;
    logic [31:0] imData;
    logic        imValid;
    logic        memReq;
    logic [31:0] memAddr;
    logic        memAck = 1'b0;
    logic [31:0] memData = 32'd0;
`ifdef SM_IFETCH_STATS_EN
    logic [31:0] missCount;
`endif

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Reference model state
    logic [31:0] q[$];
    logic [31:0] headA, fetchA, reqA, missExp;
    bit          reqOn, reqStale;

    // Stimulus state
    logic [31:0] cpuPc, branchTo;
    bit          lastValid, branchPending, rndBranch, spurious, fresh;
    int          latMin, latMax, waitLeft;

    // Trace of the first cycles for literal checks
    logic        trReq [128];
    logic        trValid [128];
    logic [31:0] trAddr [128];
    logic [31:0] trData [128];

    sm_ifetch_buffer #(.DEPTH(DEPTH), .RESET_ADDR(32'h0)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .imAddr   (imAddr),
        .imData   (imData),
        .imValid  (imValid),
        .memReq   (memReq),
        .memAddr  (memAddr),
        .memAck   (memAck),
        .memData  (memData)
`ifdef SM_IFETCH_STATS_EN
        ,
        .missCount(missCount)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memFunc(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3 ^ (a << 7);
    endfunction

    function automatic logic [31:0] pickTarget();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 127));
            1:       return 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            2:       return $urandom();
            default: return cpuPc - 32'd1;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic modelReset();
        q.delete();
        headA = 32'd0; fetchA = 32'd0; reqA = 32'd0; missExp = 32'd0;
        reqOn = 0; reqStale = 0; lastValid = 0; fresh = 1; waitLeft = 0;
        branchPending = 0;
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        memAck = 1'b0;
        #1;
        chk("rstMemReq", 32'(memReq), 32'd0);
        chk("rstImValid", 32'(imValid), 32'd0);
        chk("rstMemAddr", memAddr, 32'd0);
`ifdef SM_IFETCH_STATS_EN
        chk("rstMissCount", missCount, 32'd0);
`endif
        repeat (2) @(negedge clk);
        modelReset();
        cpuPc = 32'd0;
        imAddr = 32'd0;
        rst_n = 1'b1;
    endtask

    // One cycle: drive CPU and memory at the falling edge, compare, then advance the model
    task automatic step(input bit waitEdge);
        bit          expValid, redir, ackHit, wasIdle;
        if (waitEdge) @(negedge clk);
        if (branchPending) begin
            cpuPc = branchTo;
            branchPending = 0;
        end else if (rndBranch && $urandom_range(0, 11) == 0) begin
            cpuPc = pickTarget();
        end else if (lastValid) begin
            cpuPc = cpuPc + 32'd1;
        end
        imAddr = cpuPc;

        memAck = 1'b0;
        memData = $urandom();
        if (memReq) begin
            if (fresh) begin
                waitLeft = $urandom_range(latMin, latMax);
                fresh = 0;
            end
            if (waitLeft == 0) begin
                memAck = 1'b1;
                memData = memFunc(memAddr);
                fresh = 1;
            end else begin
                waitLeft--;
            end
        end else begin
            fresh = 1;
            if (spurious && $urandom_range(0, 7) == 0) begin
                memAck = 1'b1;
                memData = ~memFunc(memAddr);
            end
        end
        #1;

        expValid = (q.size() != 0) && (cpuPc == headA);
        chk("imValid", 32'(imValid), 32'(expValid));
        chk("memReq", 32'(memReq), 32'(reqOn));
        if (reqOn) chk("memAddr", memAddr, reqA);
        if (expValid) begin
            chk("imData", imData, q[0]);
            chk("imDataVsMem", imData, memFunc(cpuPc));
            $display("fetch cycle=%0d addr=%h data=%h", cyc, cpuPc, imData);
        end
`ifdef SM_IFETCH_STATS_EN
        chk("missCount", missCount, missExp);
`endif
        if (cyc < 128) begin
            trReq[cyc] = memReq; trValid[cyc] = imValid;
            trAddr[cyc] = memAddr; trData[cyc] = imData;
        end

        redir   = (cpuPc != headA);
        ackHit  = reqOn && memAck;
        wasIdle = !reqOn;
        if (redir && (q.size() != 0 || reqOn)) missExp = missExp + 32'd1;
        if (redir) begin
            q.delete();
            headA = cpuPc;
            fetchA = cpuPc;
            if (ackHit) reqOn = 0;
            else if (reqOn) reqStale = 1;
        end else begin
            if (expValid) begin
                void'(q.pop_front());
                headA = headA + 32'd1;
            end
            if (ackHit) begin
                if (reqStale) begin
                    reqOn = 0;
                end else begin
                    q.push_back(memData);
                    fetchA = fetchA + 32'd1;
                    if (q.size() < DEPTH) reqA = fetchA;
                    else reqOn = 0;
                end
            end
        end
        if (!reqOn) reqStale = 0;
        if (wasIdle && !redir && q.size() < DEPTH) begin
            reqOn = 1;
            reqA = fetchA;
        end
        lastValid = expValid;
        cyc++;
    endtask

    initial begin
        modelReset();
        cpuPc = 32'd0; branchTo = 32'd0;
        latMin = 0; latMax = 0; rndBranch = 0; spurious = 0;
        #2;
        applyReset();
        step(0);
        // Zero-wait streaming, a branch to 0x40, then a branch across the 2^32 wrap
        for (int i = 1; i < 40; i++) begin
            if (i == 10) begin branchPending = 1; branchTo = 32'h40; end
            if (i == 30) begin branchPending = 1; branchTo = 32'hFFFF_FFFE; end
            step(1);
        end
        chk("t1Req0", 32'(trReq[0]), 32'd0);
        for (int i = 1; i <= 4; i++) chk("t1MemAddr", trAddr[i], 32'(i - 1));
        chk("t1Valid1", 32'(trValid[1]), 32'd0);
        chk("t1Valid2", 32'(trValid[2]), 32'd1);
        chk("t1Data2", trData[2], memFunc(32'd0));
        chk("t1Data3", trData[3], memFunc(32'd1));
        chk("brValid10", 32'(trValid[10]), 32'd0);
        chk("brReq11", 32'(trReq[11]), 32'd0);
        chk("brReq12", 32'(trReq[12]), 32'd1);
        chk("brAddr12", trAddr[12], 32'h40);
        chk("brValid13", 32'(trValid[13]), 32'd1);
        chk("brData13", trData[13], memFunc(32'h40));
        chk("wrapData33", trData[33], memFunc(32'hFFFF_FFFE));
        chk("wrapValid35", 32'(trValid[35]), 32'd1);
        chk("wrapData35", trData[35], memFunc(32'h0));

        // Slow memory with redirects while a request is waiting
        latMin = 5; latMax = 5;
        for (int i = 0; i < 40; i++) begin
            if (i % 9 == 4) begin branchPending = 1; branchTo = 32'h100 + 32'(i); end
            step(1);
        end

        // Random latency, random branches, spurious acks while idle, resets mid-request
        latMin = 0; latMax = 4; rndBranch = 1; spurious = 1;
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 300; i++) step(1);
            for (int k = 0; k < 50 && !reqOn; k++) step(1);
            if (reqOn) begin
                #2;
                applyReset();
                step(0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
